jtdsp16_sout: RTL
=================

Name: jtdsp16_sout

Overview:
- Parametrised multi-channel serial output unit for the DSP16 core.
- Generalises the single-word serial output path with a configurable word width, channel count and output FIFO depth.
- Adds a per-word 8/16-bit mode, channel tagging and an overflow flag.
- Sits between the CPU register-write path (long_imm / r_field decode) and the SDO/OCK/OLD pins. Runs on cen2.

Parameters:
DW, 16, data word width in bits (8..32)
CH, 2, number of logical output channels (1..16)
AW, 2, FIFO address width; depth = 2**AW words

Ports:
rst  input  1  synchronous reset, active-high
clk  input  1  system clock
cen  input  1  clock enable (cen2); all state advances only when cen=1
wr  input  1  CPU write strobe, sampled when cen=1
wr_ch  input  max(1,$clog2(CH))  channel tag for the written word
din  input  DW  word to transmit
short_word  input  1  per-write mode: 1 = send din[7:0] only
doen  input  1  output enable; low freezes shifting
ovf_clr  input  1  clears the ovf flag
sdo  output  1  serial data out
ock  output  1  serial bit clock
old  output  1  output-load pulse, one cen wide, at each word start
ch_out  output  max(1,$clog2(CH))  channel tag of the word being shifted
ose  output  1  shifter empty (state IDLE)
obe  output  1  FIFO empty
full  output  1  FIFO full
ovf  output  1  sticky overflow flag

Behaviour:
- Reset values: sdo=0, ock=0, old=0, ch_out=0, ose=1, obe=1, full=0, ovf=0. FIFO pointers=0, state=IDLE. Reset mid-word aborts the word and flushes the FIFO.
- FIFO entry = {short_word, wr_ch, din}. A write while full with no pop in the same cen is dropped and sets ovf. Write and pop in the same cen while full: the pop frees a slot and the write is accepted.
- Writes are accepted whenever cen=1. Words with wr_ch>=CH are dropped and do not set ovf.
- ovf_clr clears ovf. If ovf_clr and a new overflow occur together, the overflow wins (ovf stays 1).
- Bit count per word: nb = short_word ? 8 : DW.
- Bit order: MSB first. Effective bit 7 is sent first in short mode.
- State machine: IDLE, SHIFT.
- IDLE: ock=0, sdo=0. On a cen with FIFO non-empty and doen=1:
  - pop, load the shifter, cnt=nb-1;
  - sdo = first bit, old=1 for this cen, ch_out = tag;
  - go to SHIFT.
- Latency: a write into an empty FIFO in IDLE produces old and the first bit on the cen after the write cen (1 cen).
- SHIFT, each cen with doen=1: ock toggles. Data changes only when ock goes 1->0, giving a bit period of 2 cen with a stable rising edge mid-bit.
  - On a falling transition with cnt>0: shift, cnt--.
  - On a falling transition with cnt==0: if the FIFO is non-empty, reload back-to-back (pop, old=1, no gap); otherwise go to IDLE with ock=0.
- doen=0 in SHIFT: ock, sdo, cnt and the shifter hold. Resume is seamless. doen=0 in IDLE blocks the start.
- ose=1 only in IDLE. obe and full reflect FIFO occupancy in the same cycle the pointers update.
- Pointer wrap: modulo 2**AW. Occupancy counter is AW+1 bits.

Optional Feature:
JTDSP16_SOUT_PARITY_EN.
- Defined: after the last data bit, one extra bit period carries even parity over the transmitted nb bits. Word period becomes 2*(nb+1) cen. Back-to-back reload happens after the parity bit.
- Undefined: no parity bit; word period is 2*nb cen.

Test Plan:
1. Reset with rst=1 for 3 cen, then release -> ose=1, obe=1, full=0, sdo=0, ock=0, ovf=0.
2. Write din=16'hA5C3, ch=1, short_word=0, doen=1 -> old high on the next cen, ch_out=1, sdo shows 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 over 32 cen; ose returns to 1 on cen 33.
3. Write 16'h00FF with short_word=1, then immediately 16'h8001 full-width -> 8 bits 11111111, then old pulses with no idle gap, then 16 bits of 8001; total 48 cen.
4. With doen=0, write 5 words into depth 4 -> full=1 after the 4th write, ovf=1 after the 5th. ovf_clr -> ovf=0. Raise doen -> exactly 4 words are sent.
5. Drop doen for 6 cen at bit 5 of a word -> ock and sdo frozen for 6 cen, no bit lost, word completes 6 cen late.
6. Parity build: send 16'h0001 -> 17 bit periods, last bit=1. Non-parity build: 16 bit periods.

Source files
------------

// File: rtl/jtdsp16_sout.sv
// rtl/jtdsp16_sout.sv - multi-channel serial output unit: tagged word FIFO feeding an MSB-first shifter
// Optional even-parity trailer bit: define JTDSP16_SOUT_PARITY_EN.
module jtdsp16_sout #(
  parameter int DW = 16,
  parameter int CH = 2,
  parameter int AW = 2,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic          wr,
  input  logic [CW-1:0] wr_ch,
  input  logic [DW-1:0] din,
  input  logic          short_word,
  input  logic          doen,
  input  logic          ovf_clr,
  output logic          sdo,
  output logic          ock,
  output logic          old,
  output logic [CW-1:0] ch_out,
  output logic          ose,
  output logic          obe,
  output logic          full,
  output logic          ovf
);

`ifdef JTDSP16_SOUT_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int DEPTH = 1 << AW;
  localparam int SW    = DW + PB;
  localparam int CNW   = $clog2(SW + 1);
  localparam int EW    = 1 + CW + DW;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          r_state, w_state_n;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [AW:0]     r_cnt;
  logic [SW-1:0]   r_sh, w_sh_n, w_load;
  logic [CNW-1:0]  r_bc, w_bc_n, w_load_cnt;
  logic            r_ock, w_ock_n;
  logic            r_old, w_old_n;
  logic            r_ovf;
  logic [CW-1:0]   r_ch, w_ch_n;
  logic            w_pop, w_push, w_wr_ok, w_ovf_set, w_empty, w_full;
  logic [EW-1:0]   w_head;
  logic            w_hshort;
  logic [CW-1:0]   w_hch;
  logic [DW-1:0]   w_hdata;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_head  = r_mem[r_rp];
  assign {w_hshort, w_hch, w_hdata} = w_head;

  // A pop in the same cen frees the slot the incoming write needs
  assign w_wr_ok   = wr && (32'(wr_ch) < CH);
  assign w_push    = w_wr_ok && (!w_full || w_pop);
  assign w_ovf_set = w_wr_ok && w_full && !w_pop;

  // Shifter image is left-aligned so sdo is always the top bit
  always_comb begin
    w_load = '0;
    if (w_hshort) w_load = SW'(w_hdata[7:0]) << (SW - 8);
    else          w_load = SW'(w_hdata) << PB;
`ifdef JTDSP16_SOUT_PARITY_EN
    if (w_hshort) w_load[SW-9] = ^w_hdata[7:0];
    else          w_load[0]    = ^w_hdata;
`endif
    w_load_cnt = w_hshort ? CNW'(8 + PB - 1) : CNW'(SW - 1);
  end

  always_comb begin
    w_state_n = r_state;
    w_sh_n    = r_sh;
    w_bc_n    = r_bc;
    w_ock_n   = r_ock;
    w_old_n   = 1'b0;
    w_ch_n    = r_ch;
    w_pop     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ock_n = 1'b0;
        if (!w_empty && doen) begin
          w_pop     = 1'b1;
          w_sh_n    = w_load;
          w_bc_n    = w_load_cnt;
          w_old_n   = 1'b1;
          w_ch_n    = w_hch;
          w_state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (doen) begin
          if (!r_ock) begin
            w_ock_n = 1'b1;
          end else begin
            w_ock_n = 1'b0;
            if (r_bc != '0) begin
              w_sh_n = r_sh << 1;
              w_bc_n = r_bc - CNW'(1);
            end else if (!w_empty) begin
              w_pop   = 1'b1;
              w_sh_n  = w_load;
              w_bc_n  = w_load_cnt;
              w_old_n = 1'b1;
              w_ch_n  = w_hch;
            end else begin
              w_state_n = IDLE;
            end
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && cen && w_push) r_mem[r_wp] <= {short_word, wr_ch, din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_bc    <= '0;
      r_ock   <= 1'b0;
      r_old   <= 1'b0;
      r_ch    <= '0;
      r_ovf   <= 1'b0;
    end else if (cen) begin
      r_state <= w_state_n;
      r_sh    <= w_sh_n;
      r_bc    <= w_bc_n;
      r_ock   <= w_ock_n;
      r_old   <= w_old_n;
      r_ch    <= w_ch_n;
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign sdo    = (r_state == SHIFT) ? r_sh[SW-1] : 1'b0;
  assign ock    = r_ock;
  assign old    = r_old;
  assign ch_out = r_ch;
  assign ose    = (r_state == IDLE);
  assign obe    = w_empty;
  assign full   = w_full;
  assign ovf    = r_ovf;

endmodule
